// File: rtl/pipe_ctl_regs.sv
// pipe_ctl_regs: PC, IF/ID, ID/EX control and mem-copy pipeline registers,
// applying hazard-unit stall/flush decisions and counting stall/flush events.
module pipe_ctl_regs #(
  parameter int DATA_WIDTH = 32,
  parameter int CTL_WIDTH = 12,
  parameter logic [DATA_WIDTH-1:0] RESET_PC = 32'h0040_0000,
  parameter int CNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] pc_next_i,
  input  logic                  pc_write_i,
  input  logic                  ifid_write_i,
  input  logic                  ifid_flush_n_i,
  input  logic                  idex_flush_n_i,
  input  logic                  ctl_flush_n_i,
  input  logic                  mem_cpy_i,
  input  logic [DATA_WIDTH-1:0] instr_i,
  input  logic [DATA_WIDTH-1:0] pc_plus4_i,
  input  logic [CTL_WIDTH-1:0]  ctl_bundle_i,
  input  logic                  cnt_clr_i,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic [DATA_WIDTH-1:0] instr_ifid_o,
  output logic [DATA_WIDTH-1:0] pc_plus4_ifid_o,
  output logic                  valid_ifid_o,
  output logic [CTL_WIDTH-1:0]  ctl_idex_o,
  output logic                  valid_idex_o,
  output logic                  mem_cpy_idex_o,
  output logic                  mem_cpy_exmem_o,
  output logic [CNT_WIDTH-1:0]  stall_cnt_o,
  output logic [CNT_WIDTH-1:0]  flush_cnt_o
);
  logic [DATA_WIDTH-1:0] pc_q, pc_d, instr_q, instr_d, pc4_q, pc4_d;
  logic                  vifid_q, vifid_d, videx_q, videx_d;
  logic [CTL_WIDTH-1:0]  ctl_q, ctl_d;
  logic                  cpy_idex_q, cpy_idex_d, cpy_exmem_q, cpy_exmem_d;
  logic [CNT_WIDTH-1:0]  stall_q, stall_d, flush_q, flush_d;
  logic                  ifid_flush, idex_bubble, flush_ev;

  always_comb begin
    pc_d        = pc_write_i ? pc_next_i : pc_q;
    // a stalled IF/ID ignores flush so a held branch in ID survives
    ifid_flush  = ifid_write_i && !ifid_flush_n_i;
    instr_d     = !ifid_write_i ? instr_q : ifid_flush ? '0 : instr_i;
    pc4_d       = !ifid_write_i ? pc4_q : ifid_flush ? '0 : pc_plus4_i;
    vifid_d     = !ifid_write_i ? vifid_q : !ifid_flush;
    idex_bubble = !ctl_flush_n_i || !idex_flush_n_i;
    ctl_d       = idex_bubble ? '0 : ctl_bundle_i;
    videx_d     = !idex_bubble && vifid_q;
    cpy_idex_d  = !idex_bubble && mem_cpy_i;
    cpy_exmem_d = cpy_idex_q;
    flush_ev    = ifid_flush || !idex_flush_n_i;
    stall_d     = cnt_clr_i ? '0 : (!pc_write_i && !(&stall_q)) ? stall_q + CNT_WIDTH'(1) : stall_q;
    flush_d     = cnt_clr_i ? '0 : (flush_ev && !(&flush_q)) ? flush_q + CNT_WIDTH'(1) : flush_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q        <= RESET_PC;
      instr_q     <= '0;
      pc4_q       <= '0;
      vifid_q     <= 1'b0;
      ctl_q       <= '0;
      videx_q     <= 1'b0;
      cpy_idex_q  <= 1'b0;
      cpy_exmem_q <= 1'b0;
      stall_q     <= '0;
      flush_q     <= '0;
    end else begin
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      pc4_q       <= pc4_d;
      vifid_q     <= vifid_d;
      ctl_q       <= ctl_d;
      videx_q     <= videx_d;
      cpy_idex_q  <= cpy_idex_d;
      cpy_exmem_q <= cpy_exmem_d;
      stall_q     <= stall_d;
      flush_q     <= flush_d;
    end
  end

  assign pc_o            = pc_q;
  assign instr_ifid_o    = instr_q;
  assign pc_plus4_ifid_o = pc4_q;
  assign valid_ifid_o    = vifid_q;
  assign ctl_idex_o      = ctl_q;
  assign valid_idex_o    = videx_q;
  assign mem_cpy_idex_o  = cpy_idex_q;
  assign mem_cpy_exmem_o = cpy_exmem_q;
  assign stall_cnt_o     = stall_q;
  assign flush_cnt_o     = flush_q;
endmodule
